// File: rtl/data_mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// Each request is answered after a fixed LATENCY, with range/alignment checking.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        write_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        resp_valid_reg;
    logic        resp_err_reg;
    logic [31:0] resp_rdata_reg;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          enter_resp;
    logic          eff_write;
    logic [31:0]   eff_addr;
    logic [31:0]   eff_wdata;
    logic          eff_err;
    logic [AW-1:0] eff_idx;
    logic          mem_we;

    assign req_ready  = (state_reg == IDLE);
    assign accept     = req_ready && req_valid;
    assign enter_resp = ((LATENCY == 1) && accept) || ((state_reg == WAIT) && (cnt_reg == 4'd0));

    // With LATENCY=1 the response is formed on the accept edge, so the live
    // inputs stand in for the not-yet-latched request.
    assign eff_write = req_ready ? req_write : write_reg;
    assign eff_addr  = req_ready ? req_addr  : addr_reg;
    assign eff_wdata = req_ready ? req_wdata : wdata_reg;
    assign eff_err   = (eff_addr[1:0] != 2'b00) || (eff_addr >= ADDR_LIMIT);
    assign eff_idx   = eff_addr[AW+1:2];
    assign mem_we    = rst_n && enter_resp && eff_write && !eff_err;

    // Storage has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[eff_idx] <= eff_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            write_reg      <= 1'b0;
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg <= req_write;
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        if (LATENCY == 1) begin
                            state_reg <= RESP;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                        resp_err_reg   <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (enter_resp) begin
                resp_valid_reg <= 1'b1;
                resp_err_reg   <= eff_err;
                resp_rdata_reg <= (!eff_write && !eff_err) ? mem[eff_idx] : 32'd0;
            end
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three builds (LATENCY 2, 1, 15)
// driven from a vector table plus hand-written reset and back-to-back sequences.
module tb_data_mem_responder;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid  [NDUT];
    logic        req_ready  [NDUT];
    logic        req_write  [NDUT];
    logic [31:0] req_addr   [NDUT];
    logic [31:0] req_wdata  [NDUT];
    logic        resp_valid [NDUT];
    logic        resp_ready [NDUT];
    logic [31:0] resp_rdata [NDUT];
    logic        resp_err   [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        data_mem_responder #(
            .DEPTH  (256),
            .LATENCY((gi == 0) ? 2 : (gi == 1) ? 1 : 15)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[gi]),
            .req_ready (req_ready[gi]),
            .req_write (req_write[gi]),
            .req_addr  (req_addr[gi]),
            .req_wdata (req_wdata[gi]),
            .resp_valid(resp_valid[gi]),
            .resp_ready(resp_ready[gi]),
            .resp_rdata(resp_rdata[gi]),
            .resp_err  (resp_err[gi])
        );
    end

    typedef struct {
        int          dut;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 15;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One request/response; resp_ready is held low for v.hold cycles after resp_valid.
    task automatic transact(input vec_t v, input string nm);
        int k;
        int lat;
        k = v.dut;
        @(negedge clk);
        req_valid[k]  = 1'b1;
        req_write[k]  = v.wr;
        req_addr[k]   = v.addr;
        req_wdata[k]  = v.wdata;
        resp_ready[k] = (v.hold == 0);
        check({nm, " req_ready_idle"}, 32'(req_ready[k]), 32'd1);
        @(posedge clk); #1;
        // Scramble inputs after the accept edge; the latched request must win.
        req_valid[k] = 1'b0;
        req_write[k] = ~v.wr;
        req_addr[k]  = 32'h0000_0004;
        req_wdata[k] = 32'hFFFF_FFFF;
        lat = 1;
        while (!resp_valid[k] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, " latency"}, 32'(lat), 32'(lat_of(k)));
        check({nm, " rdata"}, resp_rdata[k], v.exp_rdata);
        check({nm, " err"}, 32'(resp_err[k]), 32'(v.exp_err));
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            check({nm, " held_valid"}, 32'(resp_valid[k]), 32'd1);
            check({nm, " held_rdata"}, resp_rdata[k], v.exp_rdata);
            check({nm, " held_err"}, 32'(resp_err[k]), 32'(v.exp_err));
            check({nm, " held_req_ready"}, 32'(req_ready[k]), 32'd0);
        end
        resp_ready[k] = 1'b1;
        @(posedge clk); #1;
        check({nm, " done_valid"}, 32'(resp_valid[k]), 32'd0);
        check({nm, " done_err"}, 32'(resp_err[k]), 32'd0);
        check({nm, " done_req_ready"}, 32'(req_ready[k]), 32'd1);
        check({nm, " done_rdata_kept"}, resp_rdata[k], v.exp_rdata);
        $display("txn %s dut=%0d wr=%0d addr=%h wdata=%h lat=%0d rdata=%h err=%0d",
                 nm, k, v.wr, v.addr, v.wdata, lat, v.exp_rdata, v.exp_err);
    endtask

    // Hold req_valid and resp_ready high; accepts must be LATENCY+1 cycles apart.
    task automatic b2b(input int k);
        int acc [4];
        int n;
        int cyc;
        n = 0;
        cyc = 0;
        @(negedge clk);
        req_valid[k]  = 1'b1;
        req_write[k]  = 1'b0;
        req_addr[k]   = 32'h10;
        resp_ready[k] = 1'b1;
        while (n < 4 && cyc < 200) begin
            if (req_ready[k]) begin
                acc[n] = cyc;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid[k] = 1'b0;
        check($sformatf("b2b%0d accepts", k), 32'(n), 32'd4);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("b2b%0d spacing%0d", k, i), 32'(acc[i] - acc[i-1]), 32'(lat_of(k) + 1));
        end
        cyc = 0;
        while (!req_ready[k] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("b2b%0d drain", k), 32'(req_ready[k]), 32'd1);
        $display("txn b2b dut=%0d accepts at cycles %0d %0d %0d %0d", k, acc[0], acc[1], acc[2], acc[3]);
    endtask

    initial begin
        vec_t v;
        for (int k = 0; k < NDUT; k++) begin
            req_valid[k]  = 1'b0;
            req_write[k]  = 1'b0;
            req_addr[k]   = 32'd0;
            req_wdata[k]  = 32'd0;
            resp_ready[k] = 1'b1;
        end

        vecs[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,         1'b0};
        vecs[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{0, 1'b0, 32'h0000_0013, 32'h0,         0, 32'h0,         1'b1};
        vecs[3]  = '{0, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 0, 32'h0,         1'b0};
        vecs[4]  = '{0, 1'b1, 32'h0000_0400, 32'h0BAD_C0DE, 0, 32'h0,         1'b1};
        vecs[5]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         0, 32'hA5A5_A5A5, 1'b0};
        vecs[6]  = '{0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 0, 32'h0,         1'b0};
        vecs[7]  = '{0, 1'b0, 32'h0000_03FC, 32'h0,         0, 32'hCAFE_F00D, 1'b0};
        vecs[8]  = '{0, 1'b0, 32'h0000_03FE, 32'h0,         0, 32'h0,         1'b1};
        vecs[9]  = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0,         0, 32'h0,         1'b1};
        vecs[10] = '{0, 1'b0, 32'h0000_0010, 32'h0,         5, 32'hDEAD_BEEF, 1'b0};
        vecs[11] = '{0, 1'b1, 32'h0000_0013, 32'h1,         3, 32'h0,         1'b1};
        vecs[12] = '{1, 1'b1, 32'h0000_0044, 32'h1357_9BDF, 0, 32'h0,         1'b0};
        vecs[13] = '{1, 1'b0, 32'h0000_0044, 32'h0,         2, 32'h1357_9BDF, 1'b0};
        vecs[14] = '{2, 1'b1, 32'h0000_0020, 32'h1111_1111, 0, 32'h0,         1'b0};
        vecs[15] = '{2, 1'b0, 32'h0000_0020, 32'h0,         0, 32'h1111_1111, 1'b0};

        // Reset values, then release mid-cycle so the next edge is the first with rst_n=1.
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rst%0d resp_valid", k), 32'(resp_valid[k]), 32'd0);
            check($sformatf("rst%0d resp_err", k), 32'(resp_err[k]), 32'd0);
            check($sformatf("rst%0d resp_rdata", k), resp_rdata[k], 32'd0);
            check($sformatf("rst%0d req_ready", k), 32'(req_ready[k]), 32'd1);
        end
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            transact(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while WAIT on the LATENCY=15 build: the pending store must vanish.
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 32'h20;
        req_wdata[2] = 32'h55;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_wait resp_valid", 32'(resp_valid[2]), 32'd0);
        check("rst_wait req_ready", 32'(req_ready[2]), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("txn rst_wait dut=2 store 0x55 to 0x20 discarded");
        v = '{2, 1'b0, 32'h20, 32'h0, 0, 32'h1111_1111, 1'b0};
        transact(v, "after_rst_wait");

        // Reset while RESP on the LATENCY=2 build: committed store survives.
        @(negedge clk);
        req_valid[0]  = 1'b1;
        req_write[0]  = 1'b1;
        req_addr[0]   = 32'h30;
        req_wdata[0]  = 32'h7777_0077;
        resp_ready[0] = 1'b0;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        check("rst_resp valid_before", 32'(resp_valid[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_resp resp_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_resp resp_err", 32'(resp_err[0]), 32'd0);
        check("rst_resp req_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_ready[0] = 1'b1;
        $display("txn rst_resp dut=0 response dropped");
        v = '{0, 1'b0, 32'h30, 32'h0, 0, 32'h7777_0077, 1'b0};
        transact(v, "after_rst_resp");

        for (int k = 0; k < NDUT; k++) begin
            b2b(k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 256, giving the number of 32-bit words of storage (power of two, 4..1024).
REQ-002 The block SHALL have the parameter LATENCY, default 2, giving the accept-to-response delay in cycles (1..15).
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have the port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 The block SHALL have the port req_ready, output, 1 bit: the responder can accept a request this cycle.
REQ-007 The block SHALL have the port req_write, input, 1 bit: 1 means store, 0 means load.
REQ-008 The block SHALL have the port req_addr, input, 32 bits: byte address.
REQ-009 The block SHALL have the port req_wdata, input, 32 bits: store data.
REQ-010 The block SHALL have the port resp_valid, output, 1 bit: a response is presented.
REQ-011 The block SHALL have the port resp_ready, input, 1 bit: the initiator accepts the response.
REQ-012 The block SHALL have the port resp_rdata, output, 32 bits: load data, or 0 for a store or an error.
REQ-013 The block SHALL have the port resp_err, output, 1 bit: the request was misaligned or out of range.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, WAIT and RESP, encoded as a registered state.
REQ-015 req_ready SHALL be 1 only in IDLE and SHALL be combinationally independent of req_valid.
REQ-016 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_write, req_addr and req_wdata SHALL be latched at that edge, and later input changes SHALL be ignored.
REQ-017 On accept, the next state SHALL be RESP if LATENCY=1; otherwise it SHALL be WAIT, with a down-counter loaded with LATENCY-2.
REQ-018 In WAIT, the counter SHALL decrement each cycle; WAIT SHALL transition to RESP on the edge where the counter is 0.
REQ-019 resp_valid SHALL rise exactly LATENCY rising edges after the accept edge.
REQ-020 Word index SHALL be the latched addr[log2(DEPTH)+1:2].
REQ-021 An error SHALL be flagged if addr[1:0]!=0 or addr>=DEPTH*4.
REQ-022 On the edge entering RESP, a valid store SHALL write the word into memory, and resp_rdata SHALL be 0.
REQ-023 On the edge entering RESP, a valid load SHALL register the word into resp_rdata.
REQ-024 On the edge entering RESP, an error SHALL set resp_err=1 and resp_rdata=0, with no memory write.
REQ-025 In RESP, resp_valid, resp_rdata and resp_err SHALL be held stable until an edge with resp_ready=1.
REQ-026 On that edge, the state SHALL return to IDLE, resp_valid SHALL drop to 0, and resp_err SHALL clear to 0.
REQ-027 resp_rdata SHALL retain its last value in IDLE.
REQ-028 A new request SHALL NOT be accepted in the same cycle as a response handshake; the minimum spacing between accepts is LATENCY+1 cycles when resp_ready is held at 1.
REQ-029 A load to the address of a store accepted immediately before it SHALL return the stored data (no stale read).
REQ-030 Memory contents SHALL NOT be reset and are undefined until written.

Reset
REQ-031 When rst_n=0, the state SHALL be forced to IDLE immediately, asynchronously, regardless of clk.
REQ-032 Reset SHALL clear the counter to 0 and set resp_valid=0, resp_err=0 and resp_rdata=0; req_ready SHALL be 1 while in IDLE.
REQ-033 Reset asserted in WAIT SHALL discard the pending request, and its store SHALL NOT be committed.
REQ-034 Reset asserted in RESP SHALL drop the response; any store already committed SHALL remain in memory.
REQ-035 The first accept after reset SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-036 Store then load, LATENCY=2: store addr 0x10 data 0xDEADBEEF with resp_ready=1 -> resp_valid 2 edges after accept, rdata=0, err=0; load addr 0x10 -> rdata=0xDEADBEEF.
REQ-037 Misaligned and out-of-range requests: load 0x13 -> err=1, rdata=0; store 0x400 (DEPTH=256) -> err=1; a subsequent load 0x0 shows memory unchanged.
REQ-038 Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> outputs stable and req_ready=0 throughout; raising resp_ready -> return to IDLE on the next edge.
REQ-039 Reset in WAIT: assert rst_n=0 one cycle after accepting a store 0x55 to 0x20 -> resp_valid=0 immediately; a later load of 0x20 does not return 0x55.
REQ-040 LATENCY=1 and LATENCY=15 builds: resp_valid rises exactly 1 and 15 edges after accept, respectively.
REQ-041 Back-to-back requests with req_valid and resp_ready held at 1: accepts occur every LATENCY+1 cycles, with no accept in a handshake cycle.
